// File: rtl/mult_pkg.sv
// Shared definitions for the sequential-multiplier issue controller.
// Latency: n/a (types and default constants only).
// Backpressure: n/a.
package mult_pkg;

    // Default operand width; the product is twice this.
    localparam int WIDTH_DEF   = 8;

    // Default number of RUN-state cycles before the watchdog fires.
    localparam int TIMEOUT_DEF = 16;

    // Sequencer states; the encoding is fixed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_issue_ctrl_op_fifo.sv
// Purpose: synchronous operand FIFO, DEPTH x DW, head read straight from the flop array.
// Latency: a pushed entry is visible at the head one cycle later (no same-cycle bypass).
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clk, reset (sync, active-high); push/push_dat write side;
//        pop/head_dat read side; full/empty status flags.
module op_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Purpose: queue operand pairs, run the sequential multiplier one pair at a time, return products.
// Latency: LOAD to out_valid is 11 cycles with the companion multiplier; watchdog after TIMEOUT RUN cycles.
// Backpressure: in_ready = FIFO not full; out_ready low holds DONE (and the result) indefinitely.
// Ports: clk, reset (sync, active-high); in_* operand valid/ready; out_* result valid/ready
//        with out_err for watchdog results; busy; mult_* drive and observe the multiplier.
module mult_issue_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_err,
    output logic               busy,
    output logic               mult_start,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    input  logic [2*WIDTH-1:0] mult_p,
    input  logic               mult_rdy
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cyc_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [DW-1:0] fifo_head;
    logic          rdy_hit;
    logic          timeout_hit;

    op_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_op_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (in_valid),
        .push_dat ({in_a, in_b}),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state_q != IDLE);
    assign fifo_pop = (state_q == IDLE) && !fifo_empty;

    // rdy in the first RUN cycle may be left over from the previous
    // operation (the multiplier has only just left reset), so skip it.
    assign rdy_hit     = (state_q == RUN) && (cyc_cnt != '0) && mult_rdy;
    assign timeout_hit = (state_q == RUN) && !rdy_hit && (cyc_cnt == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!fifo_empty) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN:  if (rdy_hit || timeout_hit) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cyc_cnt    <= '0;
            mult_start <= 1'b1;
            mult_a     <= '0;
            mult_b     <= '0;
            out_valid  <= 1'b0;
            out_p      <= '0;
            out_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Registered so the multiplier's reset pin is glitch-free; it
            // is released only for the cycles spent in RUN.
            mult_start <= (state_d != RUN);

            if (fifo_pop) begin
                {mult_a, mult_b} <= fifo_head;
            end

            // Cleared in LOAD; leaves RUN by CNT_LAST so it never wraps.
            if (state_q == LOAD) begin
                cyc_cnt <= '0;
            end else if (state_q == RUN) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end

            if (rdy_hit) begin
                out_p     <= mult_p;
                out_err   <= 1'b0;
                out_valid <= 1'b1;
            end else if (timeout_hit) begin
                out_p     <= '0;
                out_err   <= 1'b1;
                out_valid <= 1'b1;
            end else if ((state_q == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
- Upstream sequencer for the 8-bit signed sequential multiplier.
- Accepts operand pairs over a valid/ready interface into a small FIFO, loads one pair at a time, and runs the multiplier via its start/reset line.
- Waits for the multiplier's rdy, captures the 16-bit product and returns it over a valid/ready result interface.
- A watchdog flags a multiplier that never completes.

Parameters:
- WIDTH, 8: operand width; product is 2*WIDTH.
- FIFO_DEPTH, 2: operand FIFO entries; power of two, at least 2.
- TIMEOUT, 16: RUN-state cycles allowed before the error path is taken.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  WIDTH  multiplicand, two's complement.
- in_b  in  WIDTH  multiplier operand, two's complement.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_p  out  2*WIDTH  signed product.
- out_err  out  1  result produced by watchdog expiry; out_p is 0 in that case.
- busy  out  1  high whenever the state is not IDLE.
- mult_start  out  1  drives the multiplier's reset pin; registered.
- mult_a  out  WIDTH  registered operand to the multiplier's a input.
- mult_b  out  WIDTH  registered operand to the multiplier's b input.
- mult_p  in  2*WIDTH  multiplier product.
- mult_rdy  in  1  multiplier done.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state IDLE, FIFO empty, in_ready=1, out_valid=0, out_p=0, out_err=0, busy=0, mult_start=1, mult_a=0, mult_b=0, cyc_cnt=0.
- Reset mid-operation: aborts everything; the in-flight pair and all FIFO contents are discarded.
- FIFO push: in_valid && in_ready.
- in_ready is !full. There is no push-while-full, even if a pop occurs in the same cycle.
- A push into an empty FIFO is not popped in the same cycle (no bypass). The earliest pop is the following cycle.
- IDLE: mult_start=1, which holds the multiplier cleared.
  - If the FIFO is non-empty: pop, register the head into mult_a/mult_b, go to LOAD.
- LOAD (1 cycle): mult_start=1 with mult_a/mult_b stable; the multiplier samples its operands on this edge. Clear cyc_cnt and go to RUN.
- RUN: mult_start=0 and cyc_cnt increments every cycle.
  - mult_rdy is sampled only in RUN with cyc_cnt>=1. Any stale rdy from an earlier run is ignored.
  - On mult_rdy: out_p<=mult_p, out_err<=0, out_valid<=1, go to DONE.
  - With the companion multiplier, rdy is first seen on the 9th RUN cycle, so LOAD to out_valid is 11 cycles.
  - If cyc_cnt reaches TIMEOUT-1 without rdy: out_p<=0, out_err<=1, out_valid<=1, go to DONE.
- DONE: mult_start=1 and out_p/out_err are held stable.
  - When out_ready: out_valid<=0, go to IDLE.
  - Backpressure holds DONE indefinitely; the FIFO keeps accepting pushes until full.
- Arithmetic: the block does no arithmetic on operands. Operands pass through unmodified; the product is taken as-is from mult_p.
- cyc_cnt width: $clog2(TIMEOUT)+1 bits; it never wraps.
- Ordering: results are returned strictly in push order; one operation is in flight at a time.
- Throughput: one result per 12 cycles when the consumer is always ready (IDLE, LOAD, 9 RUN cycles, DONE).

Decomposition:
- Package mult_pkg holds:
  - WIDTH default.
  - State encoding as a 2-bit enum: IDLE=0, LOAD=1, RUN=2, DONE=3.
  - TIMEOUT default.
- Sub-module op_fifo: synchronous FIFO, FIFO_DEPTH x 2*WIDTH, registered read head, full/empty flags.

Test Plan:
- Push in_a=3, in_b=5 with out_ready=1 -> out_valid after 11 cycles from LOAD, out_p=16'h000F, out_err=0.
- Push (-128,-128), then (-1,1), then (127,-128) back-to-back -> in_ready drops after 2 accepted while the first is in flight. Results in order: 16'h4000, 16'hFFFF, 16'hC080.
- Hold out_ready=0 for 20 cycles after a result -> out_valid and out_p stay stable; mult_start=1 throughout DONE; no new LOAD until the handshake.
- Tie mult_rdy=0 -> after TIMEOUT RUN cycles: out_valid=1, out_err=1, out_p=0. The next pair then completes normally with out_err=0.
- Assert reset during RUN with 2 pairs queued -> next cycle: state IDLE, FIFO empty, out_valid=0, mult_start=1. No result is produced for the discarded pairs.
- Drive mult_rdy=1 stale in IDLE and LOAD -> ignored; no out_valid until a genuine rdy in RUN with cyc_cnt>=1.
